// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, state encoding, IR field positions and strobe bundle for the ALU sequencer
package alu_seq_pkg;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_SHR   = 5'b00111;
  localparam logic [4:0] OP_SHRA  = 5'b01000;
  localparam logic [4:0] OP_SHL   = 5'b01001;
  localparam logic [4:0] OP_ROR   = 5'b01010;
  localparam logic [4:0] OP_ROL   = 5'b01011;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_NEG   = 5'b10001;
  localparam logic [4:0] OP_NOT   = 5'b10010;
  localparam logic [4:0] OP_INCPC = 5'b11111;
  localparam int OPC_MSB  = 31;
  localparam int DST_MSB  = 26;
  localparam int SRC1_MSB = 22;
  localparam int SRC2_MSB = 18;
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_ILL, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;
  typedef struct packed {
    logic pcout, pcin, marin, mdrin, mdrout, irin, yin, read;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
    logic busy, done, illegal;
  } strobe_t;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies the IR opcode and register indices into legal/unary/wide flags
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int RW       = 4
) (
  input  logic [OPC_W-1:0] opc,
  input  logic [RW-1:0]    dst,
  input  logic [RW-1:0]    src1,
  input  logic [RW-1:0]    src2,
  output logic             legal,
  output logic             unary,
  output logic             wide
);
  function automatic logic in_range(input logic [RW-1:0] x);
    return {1'b0, x} < (RW+1)'(NUM_REGS);
  endfunction
  logic binary;
  always_comb begin
    unary  = opc inside {OPC_W'(OP_NEG), OPC_W'(OP_NOT)};
    wide   = opc inside {OPC_W'(OP_MUL), OPC_W'(OP_DIV)};
    binary = opc inside {OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND), OPC_W'(OP_OR),
                         OPC_W'(OP_SHR), OPC_W'(OP_SHRA), OPC_W'(OP_SHL), OPC_W'(OP_ROR),
                         OPC_W'(OP_ROL)};
    legal  = (unary || wide || binary) && in_range(dst) && in_range(src1) && (unary || in_range(src2));
  end
endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: fetch/decode/execute control-step sequencer for register-to-register ALU instructions
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int DATA_W   = 32,
  parameter int MEM_WAIT = 0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                run,
  input  logic [DATA_W-1:0]   ir,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Read,
  output logic                ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin,
  output logic [OPC_W-1:0]    opcode,
  output logic                busy,
  output logic                done,
  output logic                illegal
);
  localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  state_t state, nxt;
  strobe_t s_d, s_q;
  logic [NUM_REGS-1:0] ri_d, ro_d, ri_q, ro_q;
  logic [OPC_W-1:0] opc, op_d, op_q;
  logic [RW-1:0] dst, src1, src2;
  logic [3:0] wcnt;
  logic legal, unary, wide, unused_ir;
  assign opc       = ir[OPC_MSB -: OPC_W];
  assign dst       = ir[DST_MSB -: RW];
  assign src1      = ir[SRC1_MSB -: RW];
  assign src2      = ir[SRC2_MSB -: RW];
  assign unused_ir = ^ir;
  alu_seq_decode #(.NUM_REGS(NUM_REGS), .OPC_W(OPC_W), .RW(RW)) u_dec (
    .opc(opc), .dst(dst), .src1(src1), .src2(src2),
    .legal(legal), .unary(unary), .wide(wide)
  );
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = start ? S_T0 : S_IDLE;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = wcnt == '0 ? S_T2 : S_T1;
      S_T2:    nxt = S_DEC;
      S_DEC:   nxt = !legal ? S_ILL : unary ? S_T4 : S_T3;
      S_T3:    nxt = S_T4;
      S_T4:    nxt = S_T5;
      S_T5:    nxt = wide ? S_T6 : S_DONE;
      S_T6:    nxt = S_DONE;
      S_DONE:  nxt = run ? S_T0 : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    s_d          = '0;
    s_d.busy     = nxt != S_IDLE;
    s_d.pcout    = nxt == S_T0;
    s_d.marin    = nxt == S_T0;
    s_d.zlowin   = nxt == S_T0 || nxt == S_T4;
    s_d.pcin     = nxt == S_T1 && state != S_T1;
    s_d.read     = nxt == S_T1;
    s_d.mdrin    = nxt == S_T1;
    s_d.zlowout  = nxt == S_T1 || nxt == S_T5;
    s_d.mdrout   = nxt == S_T2;
    s_d.irin     = nxt == S_T2;
    s_d.illegal  = nxt == S_ILL;
    s_d.yin      = nxt == S_T3;
    s_d.zhighin  = nxt == S_T4 && wide;
    s_d.loin     = nxt == S_T5 && wide;
    s_d.zhighout = nxt == S_T6;
    s_d.hiin     = nxt == S_T6;
    s_d.done     = nxt == S_DONE;
    op_d = nxt == S_T0 ? OPC_W'(OP_INCPC) : nxt == S_T4 ? opc : '0;
    ro_d = nxt == S_T3 ? NUM_REGS'(1) << src1 :
           nxt == S_T4 ? NUM_REGS'(1) << (unary ? src1 : src2) : '0;
    ri_d = nxt == S_T5 && !wide ? NUM_REGS'(1) << dst : '0;
  end
  always_ff @(posedge clock)
    if (clear) begin
      state <= S_IDLE;
      wcnt  <= '0;
      s_q   <= '0;
      ri_q  <= '0;
      ro_q  <= '0;
      op_q  <= '0;
    end else begin
      state <= nxt;
      s_q   <= s_d;
      ri_q  <= ri_d;
      ro_q  <= ro_d;
      op_q  <= op_d;
      wcnt  <= nxt == S_T1 && state != S_T1 ? 4'(MEM_WAIT) :
               state == S_T1 && wcnt != '0 ? wcnt - 4'd1 : wcnt;
    end
  assign {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Read,
          ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin, busy, done, illegal} = s_q;
  assign reg_in  = ri_q;
  assign reg_out = ro_q;
  assign opcode  = op_q;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard of per-cycle expected strobe vectors checked against two sequencer instances
module tb_alu_instr_sequencer;
  typedef struct packed {
    logic [15:0] ri, ro;
    logic [4:0]  op;
    logic pco, pci, mar, mdri, mdro, iri, yin, rd;
    logic zli, zhi, zlo, zho, hii, loi, busy, done, ill;
  } obs_t;
  logic clock = 0, clear = 1, run = 0;
  logic [31:0] ir = '0;
  logic st[2];
  obs_t o[2], obs;
  int sel = 0, tests = 0, fails = 0;
  obs_t q[$];
  always #5 clock = ~clock;
  for (genvar g = 0; g < 2; g++) begin : d
    logic [15:0] ri, ro;
    logic [4:0] op;
    logic pco, pci, mar, mdri, mdro, iri, yin, rd, zli, zhi, zlo, zho, hii, loi, busy, done, ill;
    alu_instr_sequencer #(.NUM_REGS(16), .OPC_W(5), .DATA_W(32), .MEM_WAIT(2*g)) u (
      .clock(clock), .clear(clear), .start(st[g]), .run(run), .ir(ir),
      .reg_in(ri), .reg_out(ro),
      .PCout(pco), .PCin(pci), .MARin(mar), .MDRin(mdri), .MDRout(mdro), .IRin(iri), .Yin(yin), .Read(rd),
      .ZlowIn(zli), .ZhighIn(zhi), .Zlowout(zlo), .Zhighout(zho), .HIin(hii), .LOin(loi),
      .opcode(op), .busy(busy), .done(done), .illegal(ill)
    );
    assign o[g] = {ri, ro, op, pco, pci, mar, mdri, mdro, iri, yin, rd,
                   zli, zhi, zlo, zho, hii, loi, busy, done, ill};
  end
  assign obs = o[sel];
  task automatic chk(input obs_t e, input string tag, input int n);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s cyc%0d: got %h exp %h", tag, n, obs, e);
    end
  endtask
  task automatic push_instr(input logic [31:0] i, input int mw);
    obs_t e;
    logic [4:0] oc = i[31:27];
    logic [3:0] dd = i[26:23], a = i[22:19], b = i[18:15];
    bit wide = oc inside {5'b01111, 5'b10000};
    bit un = oc inside {5'b10001, 5'b10010};
    bit ok = wide || un || oc inside {[5'b00011:5'b01011]};
    e = '0; e.busy = 1; e.pco = 1; e.mar = 1; e.zli = 1; e.op = 5'b11111; q.push_back(e);
    for (int k = 0; k <= mw; k++) begin
      e = '0; e.busy = 1; e.zlo = 1; e.rd = 1; e.mdri = 1; e.pci = k == 0; q.push_back(e);
    end
    e = '0; e.busy = 1; e.mdro = 1; e.iri = 1; q.push_back(e);
    e = '0; e.busy = 1; q.push_back(e);
    if (!ok) begin
      e.ill = 1; q.push_back(e);
      return;
    end
    if (!un) begin
      e = '0; e.busy = 1; e.ro = 16'd1 << a; e.yin = 1; q.push_back(e);
    end
    e = '0; e.busy = 1; e.ro = 16'd1 << (un ? a : b); e.op = oc; e.zli = 1; e.zhi = wide; q.push_back(e);
    e = '0; e.busy = 1; e.zlo = 1;
    if (wide) e.loi = 1; else e.ri = 16'd1 << dd;
    q.push_back(e);
    if (wide) begin
      e = '0; e.busy = 1; e.zho = 1; e.hii = 1; q.push_back(e);
    end
    e = '0; e.busy = 1; e.done = 1; q.push_back(e);
  endtask
  task automatic run_instr(input string tag, input logic [31:0] i, input int g, input int reps, input int clr_at);
    int len, n;
    sel = g;
    ir = i;
    for (int r = 0; r < reps; r++) push_instr(i, 2*g);
    len = q.size() / reps;
    n = 0;
    run = reps > 1;
    st[g] = 1;
    @(negedge clock);
    st[g] = 0;
    while (q.size() > 0) begin
      if (n == len) run = 0;
      if (n == 3) st[g] = 1;
      if (n == 4) st[g] = 0;
      chk(q.pop_front(), tag, n);
      if (n == clr_at) begin
        clear = 1;
        q.delete();
      end
      n++;
      @(negedge clock);
    end
    clear = 0;
    st[g] = 0;
    chk('0, {tag, "_idle"}, n);
    @(negedge clock);
  endtask
  initial begin
    st[0] = 0;
    st[1] = 0;
    repeat (2) @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      sel = g;
      #1 chk('0, "reset", g);
    end
    clear = 0;
    @(negedge clock);
    run_instr("add",    32'h1A1B8000, 0, 1, -1);
    run_instr("sub",    32'h221B8000, 0, 1, -1);
    run_instr("mul",    32'h781B8000, 0, 1, -1);
    run_instr("neg",    32'h8A180000, 0, 1, -1);
    run_instr("add_w2", 32'h1A1B8000, 1, 1, -1);
    run_instr("ill",    32'hF8000000, 0, 1, -1);
    run_instr("clr_t4", 32'h1A1B8000, 0, 1, 5);
    run_instr("run",    32'h1A1B8000, 0, 2, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
